regfile_wb_ctrl: RTL and testbench

Writeback controller that is the writing end of the 32×32 register file's write port. It accepts register-write requests from the ALU and the load/store unit through valid/ready handshakes and buffers them in a small queue. It drains one entry per cycle onto the register file's A3/WD3/WE3 port. It also reports pending-write hazards and bypass data for the two read addresses.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_dual_push_fifo.sv | 65 ++++++
 rtl/regfile_wb_ctrl.sv | 107 ++++++++++
 tb/tb_regfile_wb_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback controller.
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  // Writes to x0 are architecturally invisible and are dropped before queuing.
  function automatic logic is_x0(input logic [REG_AW-1:0] rd);
    return (rd == '0);
  endfunction

endpackage

// File: rtl/wb_dual_push_fifo.sv
// Circular queue with two push ports (port 0 older), one pop port, and an
// age-ordered view of every slot (index 0 = head) for hazard matching.
module wb_dual_push_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      push0_en,
  input  wb_entry_t                 push0_entry,
  input  logic                      push1_en,
  input  wb_entry_t                 push1_entry,
  input  logic                      pop_en,
  output logic [$clog2(DEPTH):0]    count,
  output wb_entry_t                 ord_entry [DEPTH],
  output logic [DEPTH-1:0]          ord_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   head_reg, head_next;
  logic [PW-1:0]   tail_reg, tail_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [PW-1:0]   slot1;

  // The second push lands right behind the first, or at the tail if alone.
  assign slot1 = tail_reg + PW'(push0_en);

  always_comb begin
    head_next  = head_reg + PW'(pop_en);
    tail_next  = tail_reg + PW'(push0_en) + PW'(push1_en);
    count_next = count_reg + CW'(push0_en) + CW'(push1_en) - CW'(pop_en);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (push0_en) mem[tail_reg] <= push0_entry;
    if (push1_en) mem[slot1]    <= push1_entry;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ord
      assign ord_entry[gi] = mem[head_reg + PW'(gi)];
      assign ord_valid[gi] = (CW'(gi) < count_reg);
    end
  endgenerate

  assign count = count_reg;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller feeding the register file A3/WD3/WE3 port from ALU and LSU.
// Optional macro WB_BYPASS_EN enables FWD1/FWD2 bypass data (otherwise tied to 0).
module regfile_wb_ctrl
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ALU_VALID,
  input  logic [REG_AW-1:0]      ALU_RD,
  input  logic [XLEN-1:0]        ALU_DATA,
  output logic                   ALU_READY,
  input  logic                   LSU_VALID,
  input  logic [REG_AW-1:0]      LSU_RD,
  input  logic [XLEN-1:0]        LSU_DATA,
  output logic                   LSU_READY,
  output logic [REG_AW-1:0]      A3,
  output logic [XLEN-1:0]        WD3,
  output logic                   WE3,
  input  logic [REG_AW-1:0]      CHK_A1,
  input  logic [REG_AW-1:0]      CHK_A2,
  output logic                   PEND1,
  output logic                   PEND2,
  output logic [XLEN-1:0]        FWD1,
  output logic [XLEN-1:0]        FWD2,
  output logic [$clog2(DEPTH):0] COUNT
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]     count;
  logic [CW-1:0]     free;
  logic              lsu_push, alu_push, pop;
  wb_entry_t         lsu_entry, alu_entry;
  wb_entry_t         ord_entry [DEPTH];
  logic [DEPTH-1:0]  ord_valid;
  logic [REG_AW-1:0] chk [2];
  logic [1:0]        pend;
  logic [XLEN-1:0]   fwd [2];

  assign free = CW'(DEPTH) - count;

  // The LSU owns the last free slot; ALU only takes it when LSU is idle.
  assign LSU_READY = (free >= CW'(1));
  assign ALU_READY = (free >= CW'(2)) || ((free == CW'(1)) && !LSU_VALID);

  assign lsu_push  = LSU_VALID && LSU_READY && !is_x0(LSU_RD);
  assign alu_push  = ALU_VALID && ALU_READY && !is_x0(ALU_RD);
  assign lsu_entry = '{rd: LSU_RD, data: LSU_DATA};
  assign alu_entry = '{rd: ALU_RD, data: ALU_DATA};
  assign pop       = (count != '0);

  wb_dual_push_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK         (CLK),
    .RST         (RST),
    .push0_en    (lsu_push),
    .push0_entry (lsu_entry),
    .push1_en    (alu_push),
    .push1_entry (alu_entry),
    .pop_en      (pop),
    .count       (count),
    .ord_entry   (ord_entry),
    .ord_valid   (ord_valid)
  );

  assign WE3   = pop;
  assign A3    = pop ? ord_entry[0].rd   : '0;
  assign WD3   = pop ? ord_entry[0].data : '0;
  assign COUNT = count;

  assign chk[0] = CHK_A1;
  assign chk[1] = CHK_A2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic            hit;
      logic [XLEN-1:0] hit_data;

      // Scan oldest to youngest so the last match wins.
      always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
          if (ord_valid[i] && !is_x0(chk[gi]) && (ord_entry[i].rd == chk[gi])) begin
            hit      = 1'b1;
            hit_data = ord_entry[i].data;
          end
        end
      end

      assign pend[gi] = hit;
`ifdef WB_BYPASS_EN
      assign fwd[gi]  = hit_data;
`else
      assign fwd[gi]  = '0;
`endif
    end
  endgenerate

  assign PEND1 = pend[0];
  assign PEND2 = pend[1];
  assign FWD1  = fwd[0];
  assign FWD2  = fwd[1];

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed, table-driven bench for regfile_wb_ctrl (DEPTH = 4).
module tb_regfile_wb_ctrl;

  localparam int DEPTH = 4;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK, RST;
  logic        ALU_VALID, LSU_VALID, ALU_READY, LSU_READY;
  logic [4:0]  ALU_RD, LSU_RD, A3, CHK_A1, CHK_A2;
  logic [31:0] ALU_DATA, LSU_DATA, WD3, FWD1, FWD2;
  logic        WE3, PEND1, PEND2;
  logic [2:0]  COUNT;

  regfile_wb_ctrl #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .ALU_VALID(ALU_VALID), .ALU_RD(ALU_RD), .ALU_DATA(ALU_DATA), .ALU_READY(ALU_READY),
    .LSU_VALID(LSU_VALID), .LSU_RD(LSU_RD), .LSU_DATA(LSU_DATA), .LSU_READY(LSU_READY),
    .A3(A3), .WD3(WD3), .WE3(WE3),
    .CHK_A1(CHK_A1), .CHK_A2(CHK_A2),
    .PEND1(PEND1), .PEND2(PEND2), .FWD1(FWD1), .FWD2(FWD2),
    .COUNT(COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] ad;
    logic lv; logic [4:0] lrd; logic [31:0] ld;
    logic [4:0] c1; logic [4:0] c2;
    logic ear; logic elr;
    logic ewe; logic [4:0] ea3; logic [31:0] ewd;
    logic [2:0] ecnt;
    logic ep1; logic [31:0] ef1;
    logic ep2; logic [31:0] ef2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic [31:0] ad,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
    input logic [4:0] c1, input logic [4:0] c2,
    input logic ear, input logic elr,
    input logic ewe, input logic [4:0] ea3, input logic [31:0] ewd,
    input logic [2:0] ecnt,
    input logic ep1, input logic [31:0] ef1,
    input logic ep2, input logic [31:0] ef2);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.c1 = c1; v.c2 = c2;
    v.ear = ear; v.elr = elr;
    v.ewe = ewe; v.ea3 = ea3; v.ewd = ewd;
    v.ecnt = ecnt;
    v.ep1 = ep1; v.ef1 = ef1; v.ep2 = ep2; v.ef2 = ef2;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic [4:0] c1, input logic [4:0] c2);
    ALU_VALID = av; ALU_RD = ard; ALU_DATA = ad;
    LSU_VALID = lv; LSU_RD = lrd; LSU_DATA = ld;
    CHK_A1 = c1; CHK_A2 = c2;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    check({p, ".alu_ready"}, 32'(ALU_READY), 32'(v.ear));
    check({p, ".lsu_ready"}, 32'(LSU_READY), 32'(v.elr));
    check({p, ".we3"},       32'(WE3),       32'(v.ewe));
    check({p, ".a3"},        32'(A3),        32'(v.ea3));
    check({p, ".wd3"},       WD3,            v.ewd);
    check({p, ".count"},     32'(COUNT),     32'(v.ecnt));
    check({p, ".pend1"},     32'(PEND1),     32'(v.ep1));
    check({p, ".fwd1"},      FWD1,           BYP ? v.ef1 : 32'h0);
    check({p, ".pend2"},     32'(PEND2),     32'(v.ep2));
    check({p, ".fwd2"},      FWD2,           BYP ? v.ef2 : 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // av ard ad | lv lrd ld | c1 c2 | ar lr | we a3 wd | cnt | p1 f1 p2 f2
    vecs.push_back(mk(0,0,0,            0,0,0,         0,0,  1,1, 0,0,0,             0, 0,0,0,0));
    vecs.push_back(mk(1,5,32'hDEADBEEF, 0,0,0,         0,0,  1,1, 0,0,0,             0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,            0,0,0,         5,0,  1,1, 1,5,32'hDEADBEEF,  1, 1,32'hDEADBEEF,0,0));
    vecs.push_back(mk(0,0,0,            0,0,0,         5,0,  1,1, 0,0,0,             0, 0,0,0,0));
    vecs.push_back(mk(1,4,32'h22,       1,3,32'h11,    0,0,  1,1, 0,0,0,             0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,            0,0,0,         3,4,  1,1, 1,3,32'h11,        2, 1,32'h11,1,32'h22));
    vecs.push_back(mk(0,0,0,            0,0,0,         3,4,  1,1, 1,4,32'h22,        1, 0,0,1,32'h22));
    vecs.push_back(mk(0,0,0,            0,0,0,         0,0,  1,1, 0,0,0,             0, 0,0,0,0));
    vecs.push_back(mk(1,0,32'hFFFF,     0,0,0,         0,0,  1,1, 0,0,0,             0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,            0,0,0,         0,0,  1,1, 0,0,0,             0, 0,0,0,0));
    vecs.push_back(mk(1,2,32'h102,      1,1,32'h101,   0,0,  1,1, 0,0,0,             0, 0,0,0,0));
    vecs.push_back(mk(1,9,32'h202,      1,8,32'h201,   2,0,  1,1, 1,1,32'h101,       2, 1,32'h102,0,0));
    vecs.push_back(mk(1,11,32'h302,     1,10,32'h301,  0,0,  0,1, 1,2,32'h102,       3, 0,0,0,0));
    vecs.push_back(mk(1,12,32'h402,     0,0,0,         0,0,  1,1, 1,8,32'h201,       3, 0,0,0,0));
    vecs.push_back(mk(1,14,32'h502,     1,13,32'h501,  0,0,  0,1, 1,9,32'h202,       3, 0,0,0,0));
    vecs.push_back(mk(0,0,0,            0,0,0,         13,12,1,1, 1,10,32'h301,      3, 1,32'h501,1,32'h402));
    vecs.push_back(mk(0,0,0,            0,0,0,         0,0,  1,1, 1,12,32'h402,      2, 0,0,0,0));
    vecs.push_back(mk(0,0,0,            0,0,0,         0,0,  1,1, 1,13,32'h501,      1, 0,0,0,0));
    vecs.push_back(mk(0,0,0,            0,0,0,         0,0,  1,1, 0,0,0,             0, 0,0,0,0));
    vecs.push_back(mk(1,7,32'hB,        1,7,32'hA,     7,0,  1,1, 0,0,0,             0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,            0,0,0,         7,0,  1,1, 1,7,32'hA,         2, 1,32'hB,0,0));
    vecs.push_back(mk(0,0,0,            0,0,0,         7,0,  1,1, 1,7,32'hB,         1, 1,32'hB,0,0));
    vecs.push_back(mk(0,0,0,            0,0,0,         7,0,  1,1, 0,0,0,             0, 0,0,0,0));
    vecs.push_back(mk(1,6,32'h66,       1,0,32'h55,    0,6,  1,1, 0,0,0,             0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,            0,0,0,         0,6,  1,1, 1,6,32'h66,        1, 0,0,1,32'h66));
    vecs.push_back(mk(0,0,0,            0,0,0,         0,6,  1,1, 0,0,0,             0, 0,0,0,0));

    // Reset held with requests valid: nothing may be queued or written.
    RST = 1'b0;
    drive(1, 5, 32'h1, 1, 6, 32'h2, 5, 6);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst.we3",       32'(WE3),       32'h0);
    check("rst.count",     32'(COUNT),     32'h0);
    check("rst.alu_ready", 32'(ALU_READY), 32'h1);
    check("rst.lsu_ready", 32'(LSU_READY), 32'h1);
    check("rst.a3",        32'(A3),        32'h0);
    check("rst.wd3",       WD3,            32'h0);
    check("rst.pend1",     32'(PEND1),     32'h0);
    check("rst.fwd1",      FWD1,           32'h0);
    $display("reset held: we3=%0d count=%0d", WE3, COUNT);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    RST = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("rel.we3",   32'(WE3),   32'h0);
    check("rel.count", 32'(COUNT), 32'h0);
    $display("reset released: we3=%0d count=%0d", WE3, COUNT);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge CLK); #1;
      drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].lv, vecs[i].lrd, vecs[i].ld,
            vecs[i].c1, vecs[i].c2);
      @(negedge CLK);
      check_vec(i, vecs[i]);
      $display("vec %0d: alu v=%0d rd=%0d lsu v=%0d rd=%0d -> we3=%0d a3=%0d wd3=%h count=%0d",
               i, vecs[i].av, vecs[i].ard, vecs[i].lv, vecs[i].lrd, WE3, A3, WD3, COUNT);
    end

    // Reset asserted mid-operation drops pending writes with no WE3 pulse.
    @(posedge CLK); #1;
    drive(1, 21, 32'h2, 1, 20, 32'h1, 0, 0);
    @(posedge CLK); #1;
    drive(0, 0, 0, 0, 0, 0, 20, 21);
    @(negedge CLK);
    check("mid.count_before", 32'(COUNT), 32'h2);
    check("mid.pend1_before", 32'(PEND1), 32'h1);
    RST = 1'b0;
    #1;
    check("mid.count", 32'(COUNT), 32'h0);
    check("mid.we3",   32'(WE3),   32'h0);
    check("mid.pend1", 32'(PEND1), 32'h0);
    check("mid.pend2", 32'(PEND2), 32'h0);
    check("mid.alu_ready", 32'(ALU_READY), 32'h1);
    $display("mid reset: count=%0d we3=%0d", COUNT, WE3);
    drive(1, 22, 32'h3, 0, 0, 0, 22, 0);
    @(posedge CLK); #1;
    check("mid.hold_count", 32'(COUNT), 32'h0);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    RST = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      check($sformatf("post.we3_%0d", k),   32'(WE3),   32'h0);
      check($sformatf("post.count_%0d", k), 32'(COUNT), 32'h0);
      $display("post reset cycle %0d: we3=%0d count=%0d", k, WE3, COUNT);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
